dlbf_data_axis2ram_capture: RTL and testbench
=============================================

DLBF_DATA_AXIS2RAM_CAPTURE -- requirements
Module: dlbf_data_axis2ram_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream and RAM word width; only 64 is supported.
REQ-002 SHALL have parameter RAM_DEPTH, default 4096, number of capture RAM words.
REQ-003 SHALL have ports: s_axis_clk  in  1  sole clock; all logic rises on it.
REQ-004 SHALL have ports: s_axis_rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: go  in  1  capture enable, level-sensitive.
REQ-006 SHALL have ports: block_size  in  12  beats per block; niter  in  12  blocks to capture, 0 = unbounded; rollover_addr  in  16  write wrap point, 0 = RAM_DEPTH.
REQ-007 SHALL have ports: s_axis_tdata  in  64; s_axis_tkeep  in  8; s_axis_tvalid  in  1; s_axis_tlast  in  1; s_axis_tready  out  1.
REQ-008 SHALL have ports: done  out  1  capture complete; tlast_err  out  1  sticky framing error; addr_wire  out  16  current write address.
REQ-009 SHALL have ports: rd_addr  in  16  readback address; rd_data  out  64  readback word.

Function
REQ-010 SHALL implement states IDLE, RUN, DONE; IDLE->RUN when go=1; RUN->DONE on last beat of block niter-1 (niter!=0); RUN->IDLE or DONE->IDLE when go=0.
REQ-011 SHALL drive s_axis_tready=1 only in RUN; beat accepted = s_axis_tvalid && s_axis_tready.
REQ-012 SHALL write each accepted beat to RAM at addr_wire, byte lane i written only when s_axis_tkeep[i]=1.
REQ-013 SHALL increment addr_wire per accepted beat, wrapping to 0 after rollover_addr-1 (after RAM_DEPTH-1 when rollover_addr=0).
REQ-014 SHALL count beats in block_counter 0..block_size-1, wrapping to 0 and incrementing iter_counter on beat block_size-1.
REQ-015 SHALL register block_size-1, niter-1 and rollover_addr-1 one cycle before use; inputs are static while go=1.
REQ-016 SHALL, with niter=0, stay in RUN indefinitely with iter_counter wrapping modulo 4096 and done=0.
REQ-017 SHALL clear addr_wire, block_counter, iter_counter on entering RUN from IDLE; DONE holds them.
REQ-018 SHALL assert done one cycle after the final beat is accepted and hold it until go=0 or reset.
REQ-019 SHALL return rd_data = RAM[rd_addr] registered, exactly 1 cycle latency, independent of state; a same-cycle write to rd_addr returns old data.
REQ-020 SHALL ignore rd_addr bits above log2(RAM_DEPTH); block_size=0 is illegal, behaviour unspecified.

Reset
REQ-021 SHALL, on s_axis_rst_n=0 at a clock edge, enter IDLE and clear s_axis_tready, done, tlast_err, addr_wire, counters, rd_data.
REQ-022 SHALL not clear RAM contents on reset; reset mid-RUN drops the in-flight beat.

Configuration
REQ-023 SHALL, with DLBF_CAPTURE_TLAST_CHECK_EN defined, set tlast_err when an accepted beat has s_axis_tlast differing from (block_counter==block_size-1); sticky until reset or IDLE->RUN.
REQ-024 SHALL, without DLBF_CAPTURE_TLAST_CHECK_EN, tie tlast_err to 0; block framing uses block_counter only, s_axis_tlast is ignored.

Verification
REQ-025 SHALL cover: block_size=4, niter=2, go=1, 8 beats tvalid=1, correct tlast -> RAM[0..7] match, done=1 one cycle after beat 8, tready=0 after.
REQ-026 SHALL cover: rollover_addr=5, niter=0, 12 beats -> writes addr 0..4,0..4,0,1; addr_wire=2; done=0.
REQ-027 SHALL cover: tkeep=8'h0F on beat to addr 3 preloaded 64'hFFFF_FFFF_FFFF_FFFF with tdata 0 -> RAM[3]=64'hFFFF_FFFF_0000_0000.
REQ-028 SHALL cover (macro on): block_size=4, tlast on beat 3 of 4 -> tlast_err=1 the following cycle, held through done; macro off -> tlast_err=0.
REQ-029 SHALL cover: tvalid toggled every other cycle, s_axis_rst_n=0 after beat 2 -> tready=0, addr_wire=0 next cycle; go held -> restart writes at addr 0.
REQ-030 SHALL cover: rd_addr=7 during RUN -> rd_data=RAM[7] one cycle later; go=0 in DONE -> done=0 next cycle.

Source files
------------

// File: rtl/dlbf_data_axis2ram_capture.sv
// rtl/dlbf_data_axis2ram_capture.sv - AXI-Stream beat capture into byte-enabled RAM with block/iteration framing
// Optional feature macro: DLBF_CAPTURE_TLAST_CHECK_EN (tlast framing check drives tlast_err)
// Ports:
//   s_axis_clk, s_axis_rst_n      clock, synchronous active-low reset
//   go                            capture enable (level)
//   block_size, niter             beats per block, blocks to capture (0 = unbounded)
//   rollover_addr                 write wrap point (0 = RAM_DEPTH)
//   s_axis_t*                     input stream; tready high only while capturing
//   done, tlast_err, addr_wire    status: complete, sticky framing error, write address
//   rd_addr, rd_data              readback port, 1-cycle registered latency
module dlbf_data_axis2ram_capture #(
  parameter int DATA_WIDTH = 64,
  parameter int RAM_DEPTH  = 4096
) (
  input  logic                    s_axis_clk,
  input  logic                    s_axis_rst_n,
  input  logic                    go,
  input  logic [11:0]             block_size,
  input  logic [11:0]             niter,
  input  logic [15:0]             rollover_addr,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    done,
  output logic                    tlast_err,
  output logic [15:0]             addr_wire,
  input  logic [15:0]             rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int AW = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [11:0]           r_bs_m1;
  logic [11:0]           r_niter_m1;
  logic                  r_unbounded;
  logic [15:0]           r_roll_m1;
  logic [11:0]           r_blk_cnt;
  logic [11:0]           r_iter_cnt;
  logic [15:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic                  w_accept;
  logic                  w_blk_last;
  logic                  w_final;
  logic                  w_start;
  logic                  w_unused_rd;

  // Configuration is static while go=1, so sampling it every cycle gives
  // stable terminal-count values by the first RUN cycle.
  always_ff @(posedge s_axis_clk) begin
    r_bs_m1     <= block_size - 12'd1;
    r_niter_m1  <= niter - 12'd1;
    r_unbounded <= (niter == 12'd0);
    r_roll_m1   <= (rollover_addr == 16'd0) ? 16'(RAM_DEPTH - 1) : rollover_addr - 16'd1;
  end

  assign w_accept   = s_axis_tvalid && s_axis_tready;
  assign w_blk_last = (r_blk_cnt == r_bs_m1);
  assign w_final    = w_accept && w_blk_last && !r_unbounded && (r_iter_cnt == r_niter_m1);
  assign w_start    = (r_state == ST_IDLE) && go;

  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    s_axis_tready = 1'b0;
    done          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (go) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        s_axis_tready = 1'b1;
        if (!go)         w_state_nxt = ST_IDLE;
        else if (w_final) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (!go) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_rst_n) begin
      r_addr     <= 16'd0;
      r_blk_cnt  <= 12'd0;
      r_iter_cnt <= 12'd0;
    end else if (w_start) begin
      r_addr     <= 16'd0;
      r_blk_cnt  <= 12'd0;
      r_iter_cnt <= 12'd0;
    end else if (w_accept) begin
      r_addr    <= (r_addr == r_roll_m1) ? 16'd0 : r_addr + 16'd1;
      r_blk_cnt <= w_blk_last ? 12'd0 : r_blk_cnt + 12'd1;
      if (w_blk_last) r_iter_cnt <= r_iter_cnt + 12'd1;
    end
  end

  assign addr_wire = r_addr;

  // RAM is never reset; a beat presented in a reset cycle is not written.
  always_ff @(posedge s_axis_clk) begin
    if (w_accept && s_axis_rst_n) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (s_axis_tkeep[i]) r_mem[r_addr[AW-1:0]][8*i +: 8] <= s_axis_tdata[8*i +: 8];
      end
    end
  end

  // Separate read process: a same-cycle write to rd_addr returns old data.
  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr[AW-1:0]];
    end
  end

  assign rd_data     = r_rd_data;
  assign w_unused_rd = ^rd_addr[15:AW];

`ifdef DLBF_CAPTURE_TLAST_CHECK_EN
  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_rst_n) begin
      tlast_err <= 1'b0;
    end else if (w_start) begin
      tlast_err <= 1'b0;
    end else if (w_accept && (s_axis_tlast != w_blk_last)) begin
      tlast_err <= 1'b1;
    end
  end
`else
  logic w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;
  assign tlast_err      = 1'b0;
`endif

endmodule

// File: tb/tb_dlbf_data_axis2ram_capture.sv
// tb/tb_dlbf_data_axis2ram_capture.sv - scoreboard bench for dlbf_data_axis2ram_capture
module tb_dlbf_data_axis2ram_capture;

`ifdef DLBF_CAPTURE_TLAST_CHECK_EN
  localparam logic TE = 1'b1;
`else
  localparam logic TE = 1'b0;
`endif

  localparam logic [63:0] D1 = 64'h1111_0000_0000_0000;
  localparam logic [63:0] D2 = 64'h2222_0000_0000_0000;
  localparam logic [63:0] D3 = 64'h3333_0000_0000_0000;
  localparam logic [63:0] D4 = 64'h4444_0000_0000_0000;
  localparam logic [63:0] D5 = 64'h5555_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        s_axis_clk = 1'b0;
  logic        s_axis_rst_n;
  logic        go;
  logic [11:0] block_size;
  logic [11:0] niter;
  logic [15:0] rollover_addr;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        done;
  logic        tlast_err;
  logic [15:0] addr_wire;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rd_req = 1'b0;
  logic        rd_vld = 1'b0;
  logic [63:0] exp_q [$];
  logic [15:0] tag_q [$];

  dlbf_data_axis2ram_capture dut (
    .s_axis_clk    (s_axis_clk),
    .s_axis_rst_n  (s_axis_rst_n),
    .go            (go),
    .block_size    (block_size),
    .niter         (niter),
    .rollover_addr (rollover_addr),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .done          (done),
    .tlast_err     (tlast_err),
    .addr_wire     (addr_wire),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  always #5 s_axis_clk = ~s_axis_clk;

  always @(posedge s_axis_clk) rd_vld <= rd_req;

  // Monitor: every read issued one cycle earlier is popped and compared.
  always @(negedge s_axis_clk) begin
    if (rd_vld) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: rd_data=%h with no expected entry", rd_data);
      end else begin
        logic [63:0] e;
        logic [15:0] t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_ram[%0d]: got %h expected %h", t, rd_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [63:0] e);
    rd_addr = a;
    rd_req  = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(a);
    @(negedge s_axis_clk);
    rd_req = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      @(negedge s_axis_clk);
      n++;
    end
    if (!s_axis_tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: tready=%0d required 1", s_axis_tready);
    end
    @(negedge s_axis_clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic start(input logic [11:0] bs, input logic [11:0] ni, input logic [15:0] ro);
    block_size    = bs;
    niter         = ni;
    rollover_addr = ro;
    go            = 1'b1;
    @(negedge s_axis_clk);
  endtask

  task automatic stop();
    go = 1'b0;
    @(negedge s_axis_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axis_rst_n  = 1'b0;
    go            = 1'b0;
    block_size    = 12'd4;
    niter         = 12'd1;
    rollover_addr = 16'd0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rd_addr       = '0;
    repeat (3) @(negedge s_axis_clk);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tlast_err", 64'(tlast_err), 64'd0);
    chk("rst_addr", 64'(addr_wire), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    s_axis_rst_n = 1'b1;
    @(negedge s_axis_clk);

    // Two blocks of four beats, correct framing.
    start(12'd4, 12'd2, 16'd0);
    for (int i = 0; i < 8; i++) begin
      send(D1 + 64'(i), 8'hFF, (i % 4) == 3);
      if (i == 6) chk("t1_done_early", 64'(done), 64'd0);
    end
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_tready", 64'(s_axis_tready), 64'd0);
    chk("t1_addr", 64'(addr_wire), 64'd8);
    chk("t1_tlast_err", 64'(tlast_err), 64'd0);
    for (int i = 0; i < 8; i++) rd(16'(i), D1 + 64'(i));
    go = 1'b0;
    @(negedge s_axis_clk);
    chk("t1_done_clear", 64'(done), 64'd0);

    // Unbounded run with rollover at 5; readback of address 7 while running.
    start(12'd4, 12'd0, 16'd5);
    for (int i = 0; i < 12; i++) send(D2 + 64'(i), 8'hFF, (i % 4) == 3);
    chk("t2_addr", 64'(addr_wire), 64'd2);
    chk("t2_done", 64'(done), 64'd0);
    chk("t2_tready", 64'(s_axis_tready), 64'd1);
    rd(16'd0, D2 + 64'd10);
    rd(16'd1, D2 + 64'd11);
    rd(16'd2, D2 + 64'd7);
    rd(16'd3, D2 + 64'd8);
    rd(16'd4, D2 + 64'd9);
    rd(16'd7, D1 + 64'd7);
    stop();

    // Byte-lane enables: preload address 3, then partial write of zeros.
    start(12'd4, 12'd1, 16'd0);
    for (int i = 0; i < 4; i++) send(ONES, 8'hFF, (i % 4) == 3);
    stop();
    start(12'd4, 12'd1, 16'd0);
    for (int i = 0; i < 3; i++) send(D3 + 64'(i), 8'hFF, 1'b0);
    send(64'd0, 8'h0F, 1'b1);
    chk("t3_done", 64'(done), 64'd1);
    rd(16'd3, 64'hFFFF_FFFF_0000_0000);
    rd(16'd2, D3 + 64'd2);
    stop();

    // tlast early on the third beat of a 4-beat block.
    start(12'd4, 12'd1, 16'd0);
    send(D4 + 64'd0, 8'hFF, 1'b0);
    send(D4 + 64'd1, 8'hFF, 1'b0);
    chk("t4_tlast_err_pre", 64'(tlast_err), 64'd0);
    send(D4 + 64'd2, 8'hFF, 1'b1);
    chk("t4_tlast_err", 64'(tlast_err), 64'(TE));
    send(D4 + 64'd3, 8'hFF, 1'b0);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_tlast_err_held", 64'(tlast_err), 64'(TE));
    stop();

    // Gapped stream, reset mid-run drops the in-flight beat, go held restarts at 0.
    start(12'd4, 12'd0, 16'd0);
    send(D5 + 64'd0, 8'hFF, 1'b0);
    @(negedge s_axis_clk);
    send(D5 + 64'd1, 8'hFF, 1'b0);
    @(negedge s_axis_clk);
    s_axis_tdata  = D5 + 64'd9;
    s_axis_tkeep  = 8'hFF;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_rst_n  = 1'b0;
    @(negedge s_axis_clk);
    chk("t5_rst_tready", 64'(s_axis_tready), 64'd0);
    chk("t5_rst_addr", 64'(addr_wire), 64'd0);
    chk("t5_rst_tlast_err", 64'(tlast_err), 64'd0);
    s_axis_rst_n  = 1'b1;
    s_axis_tvalid = 1'b0;
    send(D5 + 64'd2, 8'hFF, 1'b0);
    chk("t5_addr", 64'(addr_wire), 64'd1);
    chk("t5_tlast_err", 64'(tlast_err), 64'd0);
    rd(16'd0, D5 + 64'd2);
    rd(16'd1, D5 + 64'd1);
    rd(16'd2, D4 + 64'd2);
    stop();

    repeat (3) @(negedge s_axis_clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
